// File: rtl/tri_bus_pkg.sv
// Shared definitions for the tri-state bus receiver and the driver-side parity generator.
package tri_bus_pkg;

    localparam int unsigned TRI_BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } tri_bus_state_e;

    // Even parity bit for a bus word; callers zero-extend narrower words.
    function automatic logic tri_bus_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/tri_bus_receiver_sync_fifo.sv
// Single-clock FIFO used by tri_bus_receiver; a push into a full FIFO succeeds only with a same-edge pop.
module sync_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iPush,
    input  logic [DATA_W-1:0]          iPushData,
    input  logic                       iPopReq,
    output logic [DATA_W-1:0]          oRdData,
    output logic                       oRdValid,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oFull,
    output logic                       oDrop
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              empty;
    logic              pop;
    logic              wr;

    assign empty    = (count_q == '0);
    assign oFull    = (count_q == (AW+1)'(DEPTH));
    assign pop      = iPopReq && !empty;
    assign wr       = iPush && (!oFull || pop);
    assign oDrop    = iPush && !wr;
    assign oRdValid = !empty;
    assign oCount   = count_q;
    // Head is forced to zero when empty so the stale memory never leaks out.
    assign oRdData  = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge iClk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= iPushData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/tri_bus_receiver.sv
// Bus listener: captures one word per enable assertion after a settle interval into a FIFO.
// Optional even-parity check enabled by defining TRI_BUS_PARITY_EN.
module tri_bus_receiver
    import tri_bus_pkg::*;
#(
    parameter int unsigned DATA_W = TRI_BUS_DATA_W,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic [DATA_W-1:0]          iBus,
    input  logic                       iBusEna,
`ifdef TRI_BUS_PARITY_EN
    input  logic                       iBusPar,
    output logic                       oParErr,
`endif
    output logic [DATA_W-1:0]          oRdData,
    output logic                       oRdValid,
    input  logic                       iRdReady,
    output logic [$clog2(DEPTH):0]     oCount,
    output logic                       oFull,
    output logic                       oOverflow
);

    localparam logic [2:0] SETTLE_L = 3'(SETTLE);

    tri_bus_state_e state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           capture;
    logic           push;
    logic           drop;
    logic           ovf_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (iBusEna) begin
                    if (SETTLE == 0) begin
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d   = 3'd1;
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (!iBusEna) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_L) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_HOLD: begin
                if (!iBusEna) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        case (state_q)
            ST_IDLE:   capture = iBusEna && (SETTLE == 0);
            ST_SETTLE: capture = iBusEna && (cnt_q == SETTLE_L);
            default:   capture = 1'b0;
        endcase
    end

`ifdef TRI_BUS_PARITY_EN
    logic par_bad;
    logic par_err_q;

    assign par_bad = tri_bus_parity(64'(iBus)) ^ iBusPar;
    assign push    = capture && !par_bad;
    assign oParErr = par_err_q;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= capture && par_bad;
        end
    end
`else
    assign push = capture;
`endif

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign oOverflow = ovf_q;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .iClk      (iClk),
        .iRst      (iRst),
        .iPush     (push),
        .iPushData (iBus),
        .iPopReq   (iRdReady),
        .oRdData   (oRdData),
        .oRdValid  (oRdValid),
        .oCount    (oCount),
        .oFull     (oFull),
        .oDrop     (drop)
    );

endmodule

// File: tb/tb_tri_bus_receiver.sv
// Directed scoreboard bench for tri_bus_receiver (DATA_W=8, DEPTH=4, SETTLE=1).
module tb_tri_bus_receiver;
    import tri_bus_pkg::*;

    logic       iClk = 1'b0;
    logic       iRst;
    logic [7:0] iBus;
    logic       iBusEna;
    logic       iBusPar;
    logic       iRdReady;
    logic [7:0] oRdData;
    logic       oRdValid;
    logic [2:0] oCount;
    logic       oFull;
    logic       oOverflow;
`ifdef TRI_BUS_PARITY_EN
    logic       oParErr;
`endif

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  sb_q [$];
    int unsigned mcount   = 0;
    logic        movf     = 1'b0;

    always #5 iClk = ~iClk;

    tri_bus_receiver #(.DATA_W(8), .DEPTH(4), .SETTLE(1)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iBus      (iBus),
        .iBusEna   (iBusEna),
`ifdef TRI_BUS_PARITY_EN
        .iBusPar   (iBusPar),
        .oParErr   (oParErr),
`endif
        .oRdData   (oRdData),
        .oRdValid  (oRdValid),
        .iRdReady  (iRdReady),
        .oCount    (oCount),
        .oFull     (oFull),
        .oOverflow (oOverflow)
    );

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_count"}, 32'(oCount), 32'(mcount));
        chk({tag, "_valid"}, 32'(oRdValid), 32'(mcount != 0));
        chk({tag, "_full"},  32'(oFull), 32'(mcount == 4));
        chk({tag, "_ovf"},   32'(oOverflow), 32'(movf));
    endtask

    task automatic do_reset();
        iRst = 1'b1;
        tick();
        tick();
        iRst = 1'b0;
        sb_q.delete();
        mcount = 0;
        movf   = 1'b0;
    endtask

    // Hold enable for n edges, then one low edge; capture expected when n >= SETTLE+1.
    task automatic send(input logic [7:0] d, input int unsigned n);
        iBus    = d;
        iBusPar = tri_bus_parity(64'(d));
        iBusEna = 1'b1;
        repeat (n) tick();
        iBusEna = 1'b0;
        tick();
        if (n >= 2) begin
            if (mcount < 4) begin
                sb_q.push_back(d);
                mcount++;
            end else begin
                movf = 1'b1;
            end
        end
    endtask

    task automatic drain(input string tag);
        logic [7:0] exp;
        int unsigned guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 16) begin
            exp = sb_q.pop_front();
            chk({tag, "_hvalid"}, 32'(oRdValid), 32'd1);
            chk({tag, "_hdata"},  32'(oRdData), 32'(exp));
            iRdReady = 1'b1;
            tick();
            iRdReady = 1'b0;
            mcount--;
            guard++;
        end
        chk_status({tag, "_end"});
    endtask

    initial begin
        iRst     = 1'b1;
        iBus     = '0;
        iBusEna  = 1'b0;
        iBusPar  = 1'b0;
        iRdReady = 1'b0;
        do_reset();
        chk_status("reset");
        chk("reset_data", 32'(oRdData), 32'h0);

        // Single word, enable held 4 edges: capture on 2nd edge only.
        iBus = 8'hA5; iBusPar = tri_bus_parity(64'(8'hA5)); iBusEna = 1'b1;
        tick();
        chk("settle_cnt", 32'(oCount), 32'd0);
        tick();
        chk("cap_cnt",   32'(oCount), 32'd1);
        chk("cap_valid", 32'(oRdValid), 32'd1);
        chk("cap_data",  32'(oRdData), 32'hA5);
        tick();
        tick();
        chk("hold_cnt", 32'(oCount), 32'd1);
        iBusEna = 1'b0;
        tick();
        sb_q.push_back(8'hA5);
        mcount = 1;
        drain("single");

        // One-edge pulse aborts; ready while empty is ignored.
        send(8'h77, 1);
        chk_status("abort");
        iRdReady = 1'b1;
        tick();
        iRdReady = 1'b0;
        chk_status("empty_ready");

        // Five back-to-back words into a DEPTH=4 FIFO.
        for (int i = 1; i <= 5; i++) send(8'(i), 2);
        chk_status("overflow");
        drain("ovf_drain");

        // Full FIFO, capture edge coincides with a pop.
        do_reset();
        for (int i = 1; i <= 4; i++) send(8'(i), 2);
        chk_status("refill");
        iBus = 8'h06; iBusPar = tri_bus_parity(64'(8'h06)); iBusEna = 1'b1;
        tick();
        chk("cp_head", 32'(oRdData), 32'(sb_q.pop_front()));
        iRdReady = 1'b1;
        tick();
        iRdReady = 1'b0;
        sb_q.push_back(8'h06);
        chk_status("cp");
        iBusEna = 1'b0;
        tick();
        drain("cp_drain");

        // Reset while in SETTLE with enable still high.
        send(8'h11, 2);
        iBus = 8'h5A; iBusPar = tri_bus_parity(64'(8'h5A)); iBusEna = 1'b1;
        tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        sb_q.delete();
        mcount = 0;
        movf = 1'b0;
        chk_status("rst_mid");
        chk("rst_mid_data", 32'(oRdData), 32'h0);
        tick();
        chk("rst_settle_cnt", 32'(oCount), 32'd0);
        tick();
        sb_q.push_back(8'h5A);
        mcount = 1;
        chk_status("rst_cap");
        iBusEna = 1'b0;
        tick();
        drain("rst_drain");

`ifdef TRI_BUS_PARITY_EN
        iBus = 8'h03; iBusPar = 1'b1; iBusEna = 1'b1;
        tick();
        chk("par_pre", 32'(oParErr), 32'd0);
        tick();
        chk("par_err", 32'(oParErr), 32'd1);
        chk_status("par_drop");
        tick();
        chk("par_pulse", 32'(oParErr), 32'd0);
        iBusEna = 1'b0;
        tick();
        send(8'h03, 2);
        chk_status("par_ok");
        chk("par_ok_err", 32'(oParErr), 32'd0);
        drain("par_drain");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
